uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with configurable framing,
// majority-vote bit decisions and a show-ahead receive FIFO with sticky errors.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUDRATE    = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int N_DATA_BITS = 8,
    parameter int LSB_FIRST   = 0,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int N_STOP_BITS = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clr,
    output logic                          interrupt
);
    localparam int DIV  = (CLK_FREQ_HZ + BAUDRATE * OVERSAMPLE / 2) / (BAUDRATE * OVERSAMPLE);
    localparam int M    = OVERSAMPLE / 2;
    localparam int CW   = $clog2(DIV) > 0 ? $clog2(DIV) : 1;
    localparam int IW   = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int N    = N_DATA_BITS;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   div_q;
    logic [IW-1:0]   idx_q;
    logic [1:0]      smp_q;
    logic [N-1:0]    sh_q;
    logic [N-1:0]    sh_d;
    logic [2:0]      bit_q;
    logic            stop_q;
    logic            perr_q;
    logic            ferr_q;
    logic            ferr_d;
    logic            rx_s;
    logic            tick;
    logic            dec;
    logic            b;
    logic            last_stop;
    logic            push;
    logic            fe_set;
    logic            pe_set;
    logic            ov_set;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q;
    logic [AW-1:0]   rp_q;
    logic [CNTW-1:0] cnt_q;
    logic            frame_err_q;
    logic            parity_err_q;
    logic            overrun_err_q;
    logic            full;
    logic            pop;
    logic            wr;

    assign rx_s = sync_q[1];

    always_comb begin
        tick      = state_q != IDLE && div_q == CW'(DIV - 1);
        dec       = tick && idx_q == IW'(M + 1);
        b         = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
        sh_d      = LSB_FIRST != 0 ? {b, sh_q[N-1:1]} : {sh_q[N-2:0], b};
        ferr_d    = ferr_q | ~b;
        last_stop = state_q == STOP && dec && stop_q == 1'(N_STOP_BITS - 1);
        push      = last_stop & ~ferr_d & ~perr_q;
        fe_set    = last_stop & ferr_d;
        pe_set    = last_stop & ~ferr_d & perr_q;
        full      = cnt_q == CNTW'(FIFO_DEPTH);
        pop       = rd_en && cnt_q != '0;
        wr        = push && (!full || pop);
        ov_set    = push && full && !pop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            smp_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
            div_q  <= (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
            if (state_q == IDLE)
                idx_q <= '0;
            else if (tick)
                idx_q <= idx_q == IW'(OVERSAMPLE - 1) ? '0 : idx_q + 1'b1;
            if (tick && idx_q == IW'(M - 1))
                smp_q[0] <= rx_s;
            if (tick && idx_q == IW'(M))
                smp_q[1] <= rx_s;
            if (state_q == IDLE && !rx_s) begin
                state_q <= START;
                stop_q  <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end
            // Leaving STOP at the decision point keeps a back-to-back start edge visible.
            if (dec) begin
                case (state_q)
                    START: begin
                        state_q <= b ? IDLE : DATA;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        sh_q  <= sh_d;
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'(N - 1))
                            state_q <= PARITY_EN != 0 ? PARITY : STOP;
                    end
                    PARITY: begin
                        perr_q  <= b != (^sh_q ^ (PARITY_ODD != 0));
                        state_q <= STOP;
                    end
                    STOP: begin
                        ferr_q <= ferr_d;
                        stop_q <= 1'b1;
                        if (last_stop)
                            state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wp_q] <= 8'(sh_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q          <= '0;
            rp_q          <= '0;
            cnt_q         <= '0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            wp_q          <= wp_q + AW'(wr);
            rp_q          <= rp_q + AW'(pop);
            cnt_q         <= cnt_q + CNTW'(wr) - CNTW'(pop);
            frame_err_q   <= fe_set | (frame_err_q & ~err_clr);
            parity_err_q  <= pe_set | (parity_err_q & ~err_clr);
            overrun_err_q <= ov_set | (overrun_err_q & ~err_clr);
        end
    end

    assign rd_valid    = cnt_q != '0;
    assign rd_data     = rd_valid ? mem_q[rp_q] : 8'd0;
    assign fifo_count  = cnt_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign interrupt   = rd_valid | frame_err_q | parity_err_q | overrun_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; instance a uses default 8N1 MSB-first framing,
// instance b runs fast (DIV=2) with LSB-first even parity for the parity and overrun scenarios.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic [3:0] cnt_a, cnt_b;
    logic       fe_a, pe_a, ov_a, irq_a;
    logic       fe_b, pe_b, ov_b, irq_b;

    int total = 0;
    int bad = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #10 clk = ~clk;

    uart_rx_fifo dut_a (
        .clk(clk), .rstn(rstn), .uart_rx(rx_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_count(cnt_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a),
        .err_clr(err_clr), .interrupt(irq_a)
    );

    uart_rx_fifo #(.BAUDRATE(1562500), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rstn(rstn), .uart_rx(rx_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .fifo_count(cnt_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b),
        .err_clr(err_clr), .interrupt(irq_b)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit inst, input logic v);
        if (inst) rx_b = v;
        else rx_a = v;
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic pop(input bit inst);
        logic       exp_v, v;
        logic [7:0] exp_d, d;
        @(negedge clk);
        exp_v = inst ? (q_b.size() != 0) : (q_a.size() != 0);
        exp_d = !exp_v ? 8'h00 : inst ? q_b.pop_front() : q_a.pop_front();
        v = inst ? rd_valid_b : rd_valid_a;
        d = inst ? rd_data_b : rd_data_a;
        total++;
        if (v !== exp_v || d !== exp_d) begin
            bad++;
            $display("FAIL pop inst=%0d got valid=%b data=%h want valid=%b data=%h", inst, v, d, exp_v, exp_d);
        end
        if (inst) rd_en_b = 1'b1;
        else rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    // The pulse lands on the push cycle: start edge + 2 sync flops + 1 detect clock,
    // then DIV clocks per sample up to index 9 of the last stop bit.
    task automatic send(input bit inst, input logic [7:0] d, input bit bad_par,
                        input bit stop_v, input bit exp_push, input bit pulse);
        logic       seq [11];
        logic [7:0] exp_d, rd;
        logic       v;
        int         n, bt, wait_n;
        bt = inst ? 640 : 8680;
        wait_n = inst ? 2 + 2 * 170 : 2 + 27 * 154;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = inst ? d[i] : d[7 - i];
        n = 9;
        if (inst) begin
            seq[9] = (^d) ^ bad_par;
            n = 10;
        end
        seq[n] = stop_v;
        n++;
        if (exp_push) begin
            if (inst) q_b.push_back(d);
            else q_a.push_back(d);
        end
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    drive(inst, seq[i]);
                    #(bt);
                end
            end
            begin
                if (pulse) begin
                    repeat (wait_n) @(negedge clk);
                    exp_d = inst ? q_b.pop_front() : q_a.pop_front();
                    v = inst ? rd_valid_b : rd_valid_a;
                    rd = inst ? rd_data_b : rd_data_a;
                    total++;
                    if (v !== 1'b1 || rd !== exp_d) begin
                        bad++;
                        $display("FAIL pulse_pop inst=%0d got valid=%b data=%h want valid=1 data=%h", inst, v, rd, exp_d);
                    end
                    if (inst) rd_en_b = 1'b1;
                    else rd_en_a = 1'b1;
                    @(negedge clk);
                    rd_en_a = 1'b0;
                    rd_en_b = 1'b0;
                end
            end
        join
        drive(inst, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({rd_valid_a, cnt_a, fe_a, pe_a, ov_a, irq_a, rd_data_a} !== 17'd0) begin
            bad++;
            $display("FAIL %s_a got valid=%b cnt=%0d fe=%b pe=%b ov=%b irq=%b data=%h want all 0",
                     tag, rd_valid_a, cnt_a, fe_a, pe_a, ov_a, irq_a, rd_data_a);
        end
        total++;
        if ({rd_valid_b, cnt_b, fe_b, pe_b, ov_b, irq_b, rd_data_b} !== 17'd0) begin
            bad++;
            $display("FAIL %s_b got valid=%b cnt=%0d fe=%b pe=%b ov=%b irq=%b data=%h want all 0",
                     tag, rd_valid_b, cnt_b, fe_b, pe_b, ov_b, irq_b, rd_data_b);
        end
    endtask

    task automatic test_reset();
        idle(5);
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        send(0, 8'h57, 0, 1, 1, 0);
        idle(2);
        total++;
        if (rd_valid_a !== 1'b1 || cnt_a !== 4'd1) begin
            bad++;
            $display("FAIL single_valid got valid=%b cnt=%0d want valid=1 cnt=1", rd_valid_a, cnt_a);
        end
        pop(0);
        total++;
        if (rd_valid_a !== 1'b0 || cnt_a !== 4'd0 || irq_a !== 1'b0) begin
            bad++;
            $display("FAIL single_empty got valid=%b cnt=%0d irq=%b want 0 0 0", rd_valid_a, cnt_a, irq_a);
        end
        pop(0);
        total++;
        if (cnt_a !== 4'd0) begin
            bad++;
            $display("FAIL empty_pop got cnt=%0d want 0", cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        bytes = '{8'h57, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 5; i++) send(0, bytes[i], 0, 1, 1, 0);
        idle(2);
        total++;
        if (cnt_a !== 4'd5 || {fe_a, pe_a, ov_a} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_count got cnt=%0d flags=%b want cnt=5 flags=000", cnt_a, {fe_a, pe_a, ov_a});
        end
        for (int i = 0; i < 5; i++) pop(0);
        total++;
        if (cnt_a !== 4'd0) begin
            bad++;
            $display("FAIL b2b_drain got cnt=%0d want 0", cnt_a);
        end
    endtask

    task automatic test_frame_err();
        send(0, 8'h12, 0, 0, 0, 0);
        idle(500);
        total++;
        if (fe_a !== 1'b1 || cnt_a !== 4'd0 || irq_a !== 1'b1 || {pe_a, ov_a} !== 2'b00) begin
            bad++;
            $display("FAIL frame_err got fe=%b cnt=%0d irq=%b pe=%b ov=%b want 1 0 1 0 0", fe_a, cnt_a, irq_a, pe_a, ov_a);
        end
        clear_errors();
        total++;
        if (fe_a !== 1'b0 || irq_a !== 1'b0) begin
            bad++;
            $display("FAIL frame_clr got fe=%b irq=%b want 0 0", fe_a, irq_a);
        end
    endtask

    task automatic test_parity();
        send(1, 8'hA5, 1, 1, 0, 0);
        idle(40);
        total++;
        if (pe_b !== 1'b1 || rd_valid_b !== 1'b0 || fe_b !== 1'b0 || irq_b !== 1'b1) begin
            bad++;
            $display("FAIL parity_err got pe=%b valid=%b fe=%b irq=%b want 1 0 0 1", pe_b, rd_valid_b, fe_b, irq_b);
        end
        clear_errors();
        total++;
        if (pe_b !== 1'b0) begin
            bad++;
            $display("FAIL parity_clr got pe=%b want 0", pe_b);
        end
        send(1, 8'hA5, 0, 1, 1, 0);
        idle(4);
        pop(1);
        total++;
        if (pe_b !== 1'b0 || cnt_b !== 4'd0) begin
            bad++;
            $display("FAIL parity_ok got pe=%b cnt=%0d want 0 0", pe_b, cnt_b);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) send(1, 8'(i), 0, 1, i < 8, 0);
        idle(4);
        total++;
        if (cnt_b !== 4'd8 || ov_b !== 1'b1) begin
            bad++;
            $display("FAIL overrun got cnt=%0d ov=%b want cnt=8 ov=1", cnt_b, ov_b);
        end
        for (int i = 0; i < 8; i++) pop(1);
        total++;
        if (ov_b !== 1'b1 || cnt_b !== 4'd0) begin
            bad++;
            $display("FAIL overrun_sticky got ov=%b cnt=%0d want ov=1 cnt=0", ov_b, cnt_b);
        end
        clear_errors();
        for (int i = 0; i < 8; i++) send(1, 8'(i), 0, 1, 1, 0);
        send(1, 8'h08, 0, 1, 1, 1);
        idle(4);
        total++;
        if (cnt_b !== 4'd8 || ov_b !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_push got cnt=%0d ov=%b want cnt=8 ov=0", cnt_b, ov_b);
        end
        for (int i = 0; i < 8; i++) pop(1);
        total++;
        if (cnt_b !== 4'd0) begin
            bad++;
            $display("FAIL full_drain got cnt=%0d want 0", cnt_b);
        end
    endtask

    task automatic test_glitch_reset();
        @(negedge clk);
        rx_a = 1'b0;
        idle(3);
        rx_a = 1'b1;
        idle(600);
        total++;
        if (irq_a !== 1'b0 || cnt_a !== 4'd0) begin
            bad++;
            $display("FAIL glitch got irq=%b cnt=%0d want 0 0", irq_a, cnt_a);
        end
        send(0, 8'h33, 0, 1, 1, 0);
        send(0, 8'h44, 0, 0, 0, 0);
        idle(500);
        total++;
        if (cnt_a !== 4'd1 || fe_a !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got cnt=%0d fe=%b want cnt=1 fe=1", cnt_a, fe_a);
        end
        @(negedge clk);
        rx_a = 1'b0;
        #(8680);
        for (int i = 0; i < 4; i++) begin
            rx_a = 8'h55 >> (7 - i);
            #(8680);
        end
        rx_a = 1'b0;
        #(4340);
        rstn = 1'b0;
        idle(5);
        check_all_zero("midframe_reset");
        q_a.delete();
        q_b.delete();
        rx_a = 1'b1;
        rstn = 1'b1;
        idle(600);
        send(0, 8'h52, 0, 1, 1, 0);
        idle(4);
        pop(0);
        total++;
        if (irq_a !== 1'b0 || cnt_a !== 4'd0) begin
            bad++;
            $display("FAIL after_reset got irq=%b cnt=%0d want 0 0", irq_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_parity();
        test_overrun();
        test_glitch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
